// File: rtl/demux_1_4_collector_if.sv
// demux_1_4_collector_if: stream-in / 4-lane-out bus of the collector.
// slave = collector side, master = source + frame consumer side.
interface demux_1_4_collector_if #(
   parameter int DW = 2
);
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    sel;
   logic          sel_mode;
   logic [DW-1:0] o0;
   logic [DW-1:0] o1;
   logic [DW-1:0] o2;
   logic [DW-1:0] o3;
   logic [3:0]    lane_wr;
   logic          out_valid;
   logic          out_ack;

   modport slave (
      input  in_data, in_valid, sel, sel_mode, out_ack,
      output in_ready, o0, o1, o2, o3, lane_wr, out_valid
   );

   modport master (
      output in_data, in_valid, sel, sel_mode, out_ack,
      input  in_ready, o0, o1, o2, o3, lane_wr, out_valid
   );
endinterface

// File: rtl/demux_1_4_collector.sv
// demux_1_4_collector: distributes a 2-bit word stream into four
// registered lanes (explicit sel or auto round-robin) and flags a
// complete frame (out_valid) until out_ack.
// Ports: clk, rst_n (sync, active-low), bus (slave modport):
//   in_data/in_valid/in_ready, sel, sel_mode, o0..o3, lane_wr,
//   out_valid, out_ack.
// Option: DEMUX_CLR_ON_ACK_EN clears o0..o3 on the ack edge.
module demux_1_4_collector #(
   parameter int DW = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   demux_1_4_collector_if.slave bus
);
   typedef enum logic {
      COLLECT,
      FULL
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [3:0]    mask;
   logic [3:0]    mask_nx;
   logic [3:0]    wr_nx;
   logic [3:0]    wr_q;
   logic [1:0]    ptr;
   logic [1:0]    ptr_nx;
   logic [1:0]    lane;
   logic          acc;
   logic [DW-1:0] lane_q [4];

   assign bus.in_ready  = (state == COLLECT);
   assign bus.out_valid = (state == FULL);
   assign bus.lane_wr   = wr_q;
   assign bus.o0        = lane_q[0];
   assign bus.o1        = lane_q[1];
   assign bus.o2        = lane_q[2];
   assign bus.o3        = lane_q[3];

   assign acc  = bus.in_valid && (state == COLLECT);
   assign lane = bus.sel_mode ? ptr : bus.sel;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= COLLECT;
         mask  <= '0;
         ptr   <= '0;
         wr_q  <= '0;
      end else begin
         state <= state_nx;
         mask  <= mask_nx;
         ptr   <= ptr_nx;
         wr_q  <= wr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      mask_nx  = mask;
      ptr_nx   = ptr;
      wr_nx    = '0;
      unique case (state)
         COLLECT: begin
            if (acc) begin
               wr_nx   = 4'b0001 << lane;
               mask_nx = mask | wr_nx;
               // pointer only advances on auto-mode words
               if (bus.sel_mode)
                  ptr_nx = ptr + 2'd1;
               if (&mask_nx)
                  state_nx = FULL;
            end
         end
         FULL: begin
            if (bus.out_ack) begin
               mask_nx  = '0;
               ptr_nx   = '0;
               state_nx = COLLECT;
            end
         end
         default: state_nx = COLLECT;
      endcase
   end

   // writes happen only in COLLECT, so the ack clear never collides
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++)
            lane_q[k] <= '0;
      end else begin
`ifdef DEMUX_CLR_ON_ACK_EN
         if (state == FULL && bus.out_ack) begin
            for (int k = 0; k < 4; k++)
               lane_q[k] <= '0;
         end
`endif
         for (int k = 0; k < 4; k++)
            if (wr_nx[k])
               lane_q[k] <= bus.in_data;
      end
   end
endmodule

// File: tb/tb_demux_1_4_collector.sv
// tb_demux_1_4_collector: scoreboard bench for demux_1_4_collector.
// Expected lane writes are queued at drive time, popped on lane_wr.
module tb_demux_1_4_collector;
   typedef struct {
      logic [1:0] lane;
      logic [1:0] data;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   exp_t sb[$];
   exp_t e;

   demux_1_4_collector_if #(.DW(2)) bus ();

   demux_1_4_collector #(.DW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] lane_of(input logic [1:0] k);
      case (k)
         2'd0:    return bus.o0;
         2'd1:    return bus.o1;
         2'd2:    return bus.o2;
         default: return bus.o3;
      endcase
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // drive one word for one edge and queue its expected lane write
   task automatic drive_word(input logic [1:0] d, input logic [1:0] s,
                             input logic m, input logic [1:0] xl);
      exp_t x;
      bus.in_data  = d;
      bus.sel      = s;
      bus.sel_mode = m;
      bus.in_valid = 1'b1;
      x.lane = xl;
      x.data = d;
      sb.push_back(x);
      cyc();
      bus.in_valid = 1'b0;
   endtask

   task automatic do_ack();
      bus.out_ack = 1'b1;
      cyc();
      bus.out_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
      n_chk++;
      if ({bus.o0, bus.o1, bus.o2, bus.o3} !== 8'h00
          || bus.lane_wr !== 4'b0000 || bus.out_valid !== 1'b0
          || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset: o=%h wr=%b ov=%b rdy=%b, want 00 0000 0 1",
                  {bus.o0, bus.o1, bus.o2, bus.o3}, bus.lane_wr,
                  bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_auto();
      logic [1:0] d [4];
      d[0] = 2'd1; d[1] = 2'd2; d[2] = 2'd3; d[3] = 2'd0;
      for (int i = 0; i < 4; i++) begin
         drive_word(d[i], 2'd0, 1'b1, 2'(i));
         e = sb.pop_front();
         n_chk++;
         if (bus.lane_wr !== (4'b0001 << e.lane)
             || lane_of(e.lane) !== e.data
             || bus.out_valid !== (i == 3)) begin
            n_fail++;
            $display("FAIL auto w%0d: wr=%b o=%0d ov=%b, want %b %0d %b",
                     i, bus.lane_wr, lane_of(e.lane), bus.out_valid,
                     4'b0001 << e.lane, e.data, i == 3);
         end
      end
      cyc();
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0
          || bus.lane_wr !== 4'b0000) begin
         n_fail++;
         $display("FAIL auto hold: ov=%b rdy=%b wr=%b, want 1 0 0000",
                  bus.out_valid, bus.in_ready, bus.lane_wr);
      end
      do_ack();
      n_chk++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL auto ack: ov=%b rdy=%b, want 0 1",
                  bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_ext_overwrite();
      logic [1:0] l [5];
      logic [1:0] d [5];
      l[0] = 2; l[1] = 2; l[2] = 0; l[3] = 1; l[4] = 3;
      d[0] = 3; d[1] = 1; d[2] = 2; d[3] = 3; d[4] = 0;
      for (int i = 0; i < 5; i++) begin
         drive_word(d[i], l[i], 1'b0, l[i]);
         e = sb.pop_front();
         n_chk++;
         if (bus.lane_wr !== (4'b0001 << e.lane)
             || lane_of(e.lane) !== e.data
             || bus.out_valid !== (i == 4)) begin
            n_fail++;
            $display("FAIL ext w%0d: wr=%b o=%0d ov=%b, want %b %0d %b",
                     i, bus.lane_wr, lane_of(e.lane), bus.out_valid,
                     4'b0001 << e.lane, e.data, i == 4);
         end
      end
      n_chk++;
      if (bus.o2 !== 2'd1) begin
         n_fail++;
         $display("FAIL ext o2: got %0d want 1", bus.o2);
      end
      do_ack();
   endtask

   task automatic test_ack_valid();
      exp_t x;
      for (int i = 0; i < 4; i++) begin
         drive_word(2'd1, 2'd0, 1'b1, 2'(i));
         e = sb.pop_front();
      end
      bus.out_ack  = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 2'd3;
      bus.sel_mode = 1'b1;
      cyc();
      bus.out_ack = 1'b0;
      n_chk++;
`ifdef DEMUX_CLR_ON_ACK_EN
      x.data = 2'd0;
`else
      x.data = 2'd1;
`endif
      if (bus.lane_wr !== 4'b0000 || bus.out_valid !== 1'b0
          || bus.in_ready !== 1'b1 || bus.o0 !== x.data) begin
         n_fail++;
         $display("FAIL ackvld: wr=%b ov=%b rdy=%b o0=%0d, want 0000 0 1 %0d",
                  bus.lane_wr, bus.out_valid, bus.in_ready, bus.o0, x.data);
      end
      x.lane = 2'd0;
      x.data = 2'd3;
      sb.push_back(x);
      cyc();
      bus.in_valid = 1'b0;
      e = sb.pop_front();
      n_chk++;
      if (bus.lane_wr !== 4'b0001 || bus.o0 !== e.data) begin
         n_fail++;
         $display("FAIL ackvld held: wr=%b o0=%0d, want 0001 %0d",
                  bus.lane_wr, bus.o0, e.data);
      end
      for (int i = 1; i < 4; i++) begin
         drive_word(2'd2, 2'd0, 1'b1, 2'(i));
         e = sb.pop_front();
      end
      n_chk++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL ackvld refill: ov=%b want 1", bus.out_valid);
      end
      do_ack();
   endtask

   task automatic test_reset_mid();
      drive_word(2'd2, 2'd0, 1'b1, 2'd0);
      e = sb.pop_front();
      drive_word(2'd3, 2'd0, 1'b1, 2'd1);
      e = sb.pop_front();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      n_chk++;
      if ({bus.o0, bus.o1, bus.o2, bus.o3} !== 8'h00
          || bus.lane_wr !== 4'b0000 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid: o=%h wr=%b ov=%b, want 00 0000 0",
                  {bus.o0, bus.o1, bus.o2, bus.o3}, bus.lane_wr,
                  bus.out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         drive_word(2'(i + 1), 2'd0, 1'b1, 2'(i));
         e = sb.pop_front();
         n_chk++;
         if (bus.lane_wr !== (4'b0001 << e.lane)
             || lane_of(e.lane) !== e.data
             || bus.out_valid !== (i == 3)) begin
            n_fail++;
            $display("FAIL rstmid w%0d: wr=%b o=%0d ov=%b, want %b %0d %b",
                     i, bus.lane_wr, lane_of(e.lane), bus.out_valid,
                     4'b0001 << e.lane, e.data, i == 3);
         end
      end
      do_ack();
   endtask

   task automatic test_mode_switch();
      drive_word(2'd1, 2'd0, 1'b1, 2'd0);
      e = sb.pop_front();
      drive_word(2'd2, 2'd0, 1'b1, 2'd1);
      e = sb.pop_front();
      drive_word(2'd3, 2'd3, 1'b0, 2'd3);
      e = sb.pop_front();
      n_chk++;
      if (bus.lane_wr !== 4'b1000 || bus.o3 !== 2'd3
          || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL modesw sel3: wr=%b o3=%0d ov=%b, want 1000 3 0",
                  bus.lane_wr, bus.o3, bus.out_valid);
      end
      drive_word(2'd0, 2'd2, 1'b0, 2'd2);
      e = sb.pop_front();
      n_chk++;
      if (bus.lane_wr !== 4'b0100 || bus.o2 !== 2'd0
          || bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL modesw sel2: wr=%b o2=%0d ov=%b, want 0100 0 1",
                  bus.lane_wr, bus.o2, bus.out_valid);
      end
      do_ack();
      drive_word(2'd2, 2'd0, 1'b1, 2'd0);
      e = sb.pop_front();
      n_chk++;
      if (bus.lane_wr !== (4'b0001 << e.lane) || bus.o0 !== e.data) begin
         n_fail++;
         $display("FAIL modesw ptr: wr=%b o0=%0d, want %b %0d",
                  bus.lane_wr, bus.o0, 4'b0001 << e.lane, e.data);
      end
      for (int i = 1; i < 4; i++) begin
         drive_word(2'd1, 2'd0, 1'b1, 2'(i));
         e = sb.pop_front();
      end
      do_ack();
   endtask

   task automatic test_clr_on_ack();
      logic [1:0] d [4];
      logic [7:0] want;
      d[0] = 2'd1; d[1] = 2'd2; d[2] = 2'd3; d[3] = 2'd1;
      for (int i = 0; i < 4; i++) begin
         drive_word(d[i], 2'd0, 1'b1, 2'(i));
         e = sb.pop_front();
      end
      do_ack();
`ifdef DEMUX_CLR_ON_ACK_EN
      want = 8'h00;
`else
      want = {2'd1, 2'd2, 2'd3, 2'd1};
`endif
      n_chk++;
      if ({bus.o0, bus.o1, bus.o2, bus.o3} !== want
          || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL clr: o=%h ov=%b, want %h 0",
                  {bus.o0, bus.o1, bus.o2, bus.o3}, bus.out_valid, want);
      end
   endtask

   initial begin
      n_chk        = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      bus.sel      = '0;
      bus.sel_mode = 1'b0;
      bus.out_ack  = 1'b0;
      test_reset();
      test_auto();
      test_ext_overwrite();
      test_ack_valid();
      test_reset_mid();
      test_mode_switch();
      test_clr_on_ack();
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
